// File: rtl/fsm_step_ctrl.sv
// Sequencer/checker that walks the X-step FSM through S1,S2,S3 and verifies Z1/Z2 after each X pulse.
// Optional error-capture outputs err_step/err_z are enabled by defining FSM_STEP_CTRL_ERRSTEP_EN.
module fsm_step_ctrl #(
   parameter int STEP_GAP = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   input  logic       z1_in,
   input  logic       z2_in,
   output logic       x_out,
   output logic       fsm_clr_n,
   output logic       busy,
   output logic       done,
   output logic       err,
`ifdef FSM_STEP_CTRL_ERRSTEP_EN
   output logic [1:0] err_step,
   output logic [1:0] err_z,
`endif
   output logic [1:0] step_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam logic [3:0] GAP_LOAD = 4'(STEP_GAP);

   logic [2:0] state;
   logic [2:0] nxt;
   logic [3:0] gap_cnt;
   logic       z_ok;

   // After the third pulse the FSM must sit in S3 (Z2 only); before that in S1/S2 (Z1 only).
   always_comb begin
      z_ok = 1'b0;
      if (step_cnt == 2'd3)
         z_ok = !z1_in && z2_in;
      else
         z_ok = z1_in && !z2_in;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (start && !abort) nxt = S_CLEAR;
         S_CLEAR: nxt = S_PULSE;
         S_PULSE: nxt = S_GAP;
         S_GAP:   if (gap_cnt == 4'd1) nxt = S_CHECK;
         S_CHECK: begin
            if (!z_ok)
               nxt = S_ERR;
            else if (step_cnt == 2'd3)
               nxt = S_DONE;
            else
               nxt = S_PULSE;
         end
         S_DONE:  nxt = S_IDLE;
         S_ERR:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      // DONE/ERR already return to IDLE, so their pulse survives a late abort.
      if (abort && state != S_IDLE)
         nxt = S_IDLE;
   end

   // Outputs are registered decodes of the next state so each is high exactly while its state is current.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         gap_cnt   <= 4'd0;
         x_out     <= 1'b0;
         fsm_clr_n <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         step_cnt  <= 2'd0;
      end else begin
         state     <= nxt;
         x_out     <= (nxt == S_PULSE);
         fsm_clr_n <= (nxt != S_CLEAR);
         busy      <= (nxt == S_CLEAR) || (nxt == S_PULSE) ||
                      (nxt == S_GAP)   || (nxt == S_CHECK);
         done      <= (nxt == S_DONE);
         err       <= (nxt == S_ERR);
         if (nxt == S_CLEAR)
            step_cnt <= 2'd0;
         else if (nxt == S_PULSE)
            step_cnt <= step_cnt + 2'd1;
         if (state == S_PULSE)
            gap_cnt <= GAP_LOAD;
         else if (state == S_GAP)
            gap_cnt <= gap_cnt - 4'd1;
      end
   end

`ifdef FSM_STEP_CTRL_ERRSTEP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_step <= 2'd0;
         err_z    <= 2'd0;
      end else if (nxt == S_ERR) begin
         err_step <= step_cnt;
         err_z    <= {z2_in, z1_in};
      end else if (nxt == S_CLEAR) begin
         err_step <= 2'd0;
         err_z    <= 2'd0;
      end
   end
`endif

endmodule
